start_store_banked: RTL and testbench
=====================================

# start_store_banked

Parametrised successor to the per-layer start/activation store in the data path. Holds an activation vector and a start vector per (set, row, address) entry, and serves one registered read per cycle. Each read returns one of four lane-wise combinations of the two vectors: saturating fixed-point product, activation only, start only, or saturating difference. Adds multiple layer sets, per-entry valid tracking, per-set clear, synchronous reset and range checking.

## Interface
- `data_size`, 16, lane width in bits, signed fixed point
- `frac_bits`, 8, fractional bits per lane (Q(data_size-frac_bits).frac_bits)
- `size`, 3, lanes per vector; also the number of rows
- `max_layer_size`, 5, addresses per row
- `num_sets`, 2, independent layer sets (banks)

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `store` in 1: write enable
- `store_set` in 32: target set
- `store_row` in 32: target row
- `store_address` in 32: target address
- `store_act_data` in data_size*size: activation vector, lane 0 in MSBs
- `store_start_data` in data_size*size: start vector, lane 0 in MSBs
- `load` in 1: read request
- `load_set` in 32: source set
- `load_row` in 32: source row
- `load_address` in 32: source address
- `load_mode` in 2: 0 product, 1 act, 2 start, 3 act minus start
- `clear` in 1: invalidate every entry of `clear_set`
- `clear_set` in 32: set to invalidate
- `load_valid` out 1: `load_data` is valid this cycle
- `load_data` out data_size*size: result vector, lane 0 in MSBs
- `load_error` out 1: qualifies `load_valid`; the request was out of range

## Operation
- Storage:
  - `num_sets*size*max_layer_size` entries, each holding an act vector and a start vector.
  - One valid bit per entry. Vector contents are not reset.
- Store:
  - When `store` is high and all indices are in range, write both vectors and set the entry's valid bit.
  - An out-of-range store is silently dropped.
- Clear:
  - Clears the valid bits of every entry in `clear_set`. Stored data is untouched.
  - An out-of-range `clear_set` is ignored.
- Load operand selection, in priority order:
  1. Same-cycle `store` to the identical (set, row, address): operands are the store inputs (write-through bypass).
  2. Entry valid and not being cleared this cycle: operands are the stored vectors.
  3. Otherwise: both operands are zero.
- Lane arithmetic, all signed:
  - Mode 0: full 2*data_size product, arithmetic shift right by `frac_bits` (truncate toward −inf), saturate to [−2^(data_size−1), 2^(data_size−1)−1].
  - Mode 1: act, passed through.
  - Mode 2: start, passed through.
  - Mode 3: act − start, computed at data_size+1 bits, then saturated.
- Out-of-range load (any index ≥ its bound):
  - `load_valid`=1, `load_error`=1, `load_data`=0.
  - No storage access.
- Store and clear to the same set in the same cycle: clear applies first, so the stored entry ends valid.

## Timing
- Reset values: `load_valid`=0, `load_data`=0, `load_error`=0, all valid bits 0.
- Reset takes priority over store, clear and load in the same cycle.
- Read latency is 1 cycle:
  - `load` sampled high at edge N gives `load_valid`=1 and the result after edge N, held for one cycle.
  - With `load` low, `load_valid`=0, `load_data`=0, `load_error`=0.
- Full throughput: one load and one store per cycle, back-to-back, no stall.
- A store at edge N is visible to a non-bypassed load sampled at edge N+1.
- A clear at edge N affects loads sampled at edge N (see operand priority) and all later loads.
- Reset asserted while a load result is pending: the result is discarded, and outputs are zero the cycle after the reset edge.

## Test plan
- Product: store set1/row0/addr2 act lanes {0x0200, 0xFF00, 0x0080}, start {0x0180, 0x0200, 0x0400}; load mode 0 next cycle -> `load_data` lanes {0x0300, 0xFE00, 0x0200}, `load_valid`=1 one cycle later.
- Saturation: act 0x7F00 × start 0x0200 -> 0x7FFF. Mode 3 with act 0x8000, start 0x0100 -> 0x8000.
- Bypass: store and load of the same location in the same cycle with new act 0x0100, start 0x0300 -> mode 0 returns 0x0300. A different location in the same cycle returns its old value.
- Clear: fill set0 and set1; clear set0 -> set0 loads return 0 in all modes, set1 loads are unchanged. Store + clear of set0 in the same cycle -> that entry reads back valid.
- Range: `load_row`=3 with size=3 -> `load_valid`=1, `load_error`=1, data 0. A store with address 5 is dropped and no entry changes.
- Reset: fill entries, assert `reset` for 1 cycle with `load` high -> outputs 0 the next cycle; all subsequent loads return 0 until the entries are restored.

Source files
------------

// File: rtl/start_store_banked.sv
// rtl/start_store_banked.sv - banked act/start vector store with one registered combining read per cycle
// Entries are flattened as ((set*size + row)*max_layer_size + address); lane 0 sits in the MSBs.
module start_store_banked #(
  parameter int data_size      = 16,
  parameter int frac_bits      = 8,
  parameter int size           = 3,
  parameter int max_layer_size = 5,
  parameter int num_sets       = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_store,
  input  logic [31:0]               i_store_set,
  input  logic [31:0]               i_store_row,
  input  logic [31:0]               i_store_address,
  input  logic [data_size*size-1:0] i_store_act_data,
  input  logic [data_size*size-1:0] i_store_start_data,
  input  logic                      i_load,
  input  logic [31:0]               i_load_set,
  input  logic [31:0]               i_load_row,
  input  logic [31:0]               i_load_address,
  input  logic [1:0]                i_load_mode,
  input  logic                      i_clear,
  input  logic [31:0]               i_clear_set,
  output logic                      o_load_valid,
  output logic [data_size*size-1:0] o_load_data,
  output logic                      o_load_error
);

  localparam int W           = data_size * size;
  localparam int SET_ENTRIES = size * max_layer_size;
  localparam int ENTRIES     = num_sets * SET_ENTRIES;
  localparam int IDX_W       = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [W-1:0]       r_act   [ENTRIES];
  logic [W-1:0]       r_start [ENTRIES];
  logic [ENTRIES-1:0] r_valid;

  logic             w_st_ok, w_ld_ok, w_clr_ok;
  logic [IDX_W-1:0] w_st_idx, w_ld_idx;
  logic [W-1:0]     w_act_op, w_start_op, w_result;

  assign w_st_ok  = i_store && (i_store_set < 32'(num_sets)) && (i_store_row < 32'(size))
                    && (i_store_address < 32'(max_layer_size));
  assign w_ld_ok  = (i_load_set < 32'(num_sets)) && (i_load_row < 32'(size))
                    && (i_load_address < 32'(max_layer_size));
  assign w_clr_ok = i_clear && (i_clear_set < 32'(num_sets));
  assign w_st_idx = IDX_W'((i_store_set * size + i_store_row) * max_layer_size + i_store_address);
  assign w_ld_idx = IDX_W'((i_load_set * size + i_load_row) * max_layer_size + i_load_address);

  // Product keeps the full 2*data_size width so the shift truncates toward -inf before saturating.
  function automatic logic [data_size-1:0] f_lane(input logic [1:0] mode,
                                                  input logic signed [data_size-1:0] a,
                                                  input logic signed [data_size-1:0] b);
    logic signed [2*data_size-1:0] p;
    logic signed [data_size:0]     d;
    f_lane = '0;
    case (mode)
      2'd0: begin
        p = a * b;
        p = p >>> frac_bits;
        if ((&p[2*data_size-1:data_size-1]) || !(|p[2*data_size-1:data_size-1]))
          f_lane = p[data_size-1:0];
        else
          f_lane = p[2*data_size-1] ? {1'b1, {(data_size-1){1'b0}}} : {1'b0, {(data_size-1){1'b1}}};
      end
      2'd1: f_lane = a;
      2'd2: f_lane = b;
      default: begin
        d = a - b;
        if (d[data_size] == d[data_size-1])
          f_lane = d[data_size-1:0];
        else
          f_lane = d[data_size] ? {1'b1, {(data_size-1){1'b0}}} : {1'b0, {(data_size-1){1'b1}}};
      end
    endcase
  endfunction

  always_comb begin
    w_act_op   = '0;
    w_start_op = '0;
    if (w_st_ok && w_ld_ok && (w_st_idx == w_ld_idx)) begin
      w_act_op   = i_store_act_data;
      w_start_op = i_store_start_data;
    end else if (w_ld_ok && r_valid[w_ld_idx] && !(w_clr_ok && (i_clear_set == i_load_set))) begin
      w_act_op   = r_act[w_ld_idx];
      w_start_op = r_start[w_ld_idx];
    end
  end

  always_comb begin
    w_result = '0;
    for (int i = 0; i < size; i++)
      w_result[W-1-i*data_size -: data_size] =
        f_lane(i_load_mode, w_act_op[W-1-i*data_size -: data_size],
               w_start_op[W-1-i*data_size -: data_size]);
  end

  always_ff @(posedge i_clk) begin
    if (w_st_ok) begin
      r_act[w_st_idx]   <= i_store_act_data;
      r_start[w_st_idx] <= i_store_start_data;
    end
  end

  // The store's set comes after the clear loop so a same-cycle store survives a clear of its set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
    end else begin
      for (int e = 0; e < ENTRIES; e++)
        if (w_clr_ok && (32'(e / SET_ENTRIES) == i_clear_set))
          r_valid[e] <= 1'b0;
      if (w_st_ok)
        r_valid[w_st_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_load_valid <= 1'b0;
      o_load_error <= 1'b0;
      o_load_data  <= '0;
    end else begin
      o_load_valid <= i_load;
      o_load_error <= i_load && !w_ld_ok;
      o_load_data  <= (i_load && w_ld_ok) ? w_result : '0;
    end
  end

endmodule

// File: tb/tb_start_store_banked.sv
// tb/tb_start_store_banked.sv - directed self-checking bench for start_store_banked
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_start_store_banked;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        store = 1'b0;
  logic [31:0] store_set = '0, store_row = '0, store_address = '0;
  logic [47:0] store_act_data = '0, store_start_data = '0;
  logic        load = 1'b0;
  logic [31:0] load_set = '0, load_row = '0, load_address = '0;
  logic [1:0]  load_mode = '0;
  logic        clear = 1'b0;
  logic [31:0] clear_set = '0;
  logic        load_valid, load_error;
  logic [47:0] load_data;
  logic [49:0] exp_v;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  start_store_banked dut (
    .i_clk(clk), .i_reset(reset), .i_store(store), .i_store_set(store_set),
    .i_store_row(store_row), .i_store_address(store_address),
    .i_store_act_data(store_act_data), .i_store_start_data(store_start_data),
    .i_load(load), .i_load_set(load_set), .i_load_row(load_row),
    .i_load_address(load_address), .i_load_mode(load_mode),
    .i_clear(clear), .i_clear_set(clear_set),
    .o_load_valid(load_valid), .o_load_data(load_data), .o_load_error(load_error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input int s, input int r, input int a, input logic [47:0] act,
                           input logic [47:0] st);
    store = 1'b1; store_set = s; store_row = r; store_address = a;
    store_act_data = act; store_start_data = st;
  endtask

  task automatic set_load(input int s, input int r, input int a, input int m);
    load = 1'b1; load_set = s; load_row = r; load_address = a; load_mode = 2'(m);
  endtask

  task automatic idle;
    store = 1'b0; load = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    n_vec++;
    if ({load_valid, load_error, load_data} !== 50'h0) begin
      n_err++; $display("FAIL reset_outputs got %h want %h", {load_valid, load_error, load_data}, 50'h0);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_product;
    set_store(1, 0, 2, 48'h0200_FF00_0080, 48'h0180_0200_0400); tick(); idle();
    for (int m = 0; m < 4; m++) begin
      set_load(1, 0, 2, m); tick(); idle();
      case (m)
        0: exp_v = {2'b10, 48'h0300_FE00_0200};
        1: exp_v = {2'b10, 48'h0200_FF00_0080};
        2: exp_v = {2'b10, 48'h0180_0200_0400};
        default: exp_v = {2'b10, 48'h0080_FD00_FC80};
      endcase
      n_vec++;
      if ({load_valid, load_error, load_data} !== exp_v) begin
        n_err++; $display("FAIL product_mode%0d got %h want %h", m, {load_valid, load_error, load_data}, exp_v);
      end
    end
    tick();
    n_vec++;
    if ({load_valid, load_error, load_data} !== 50'h0) begin
      n_err++; $display("FAIL product_hold got %h want %h", {load_valid, load_error, load_data}, 50'h0);
    end
  endtask

  task automatic test_saturation;
    set_store(0, 1, 0, 48'h7F00_8000_FFFF, 48'h0200_0100_0080); tick(); idle();
    set_load(0, 1, 0, 0); tick(); idle();
    exp_v = {2'b10, 48'h7FFF_8000_FFFF};
    n_vec++;
    if ({load_valid, load_error, load_data} !== exp_v) begin
      n_err++; $display("FAIL sat_product got %h want %h", {load_valid, load_error, load_data}, exp_v);
    end
    set_load(0, 1, 0, 3); tick(); idle();
    exp_v = {2'b10, 48'h7D00_8000_FF7F};
    n_vec++;
    if ({load_valid, load_error, load_data} !== exp_v) begin
      n_err++; $display("FAIL sat_diff got %h want %h", {load_valid, load_error, load_data}, exp_v);
    end
  endtask

  task automatic test_bypass;
    set_store(0, 2, 4, 48'h0200_0200_0200, 48'h0100_0100_0100); tick(); idle();
    set_store(0, 2, 4, 48'h0100_0100_0100, 48'h0300_0300_0300);
    set_load(0, 2, 4, 0); tick(); idle();
    exp_v = {2'b10, 48'h0300_0300_0300};
    n_vec++;
    if ({load_valid, load_error, load_data} !== exp_v) begin
      n_err++; $display("FAIL bypass_same got %h want %h", {load_valid, load_error, load_data}, exp_v);
    end
    set_store(0, 2, 3, 48'h0400_0400_0400, 48'h0100_0100_0100);
    set_load(0, 2, 4, 0); tick(); idle();
    exp_v = {2'b10, 48'h0300_0300_0300};
    n_vec++;
    if ({load_valid, load_error, load_data} !== exp_v) begin
      n_err++; $display("FAIL bypass_other got %h want %h", {load_valid, load_error, load_data}, exp_v);
    end
    set_load(0, 2, 3, 0); tick(); idle();
    exp_v = {2'b10, 48'h0400_0400_0400};
    n_vec++;
    if ({load_valid, load_error, load_data} !== exp_v) begin
      n_err++; $display("FAIL bypass_landed got %h want %h", {load_valid, load_error, load_data}, exp_v);
    end
  endtask

  task automatic test_range;
    set_load(0, 3, 0, 1); tick(); idle();
    n_vec++;
    if ({load_valid, load_error, load_data} !== {2'b11, 48'h0}) begin
      n_err++; $display("FAIL range_row got %h want %h", {load_valid, load_error, load_data}, {2'b11, 48'h0});
    end
    set_load(2, 0, 2, 1); tick(); idle();
    n_vec++;
    if ({load_valid, load_error, load_data} !== {2'b11, 48'h0}) begin
      n_err++; $display("FAIL range_set got %h want %h", {load_valid, load_error, load_data}, {2'b11, 48'h0});
    end
    set_load(0, 0, 5, 1); tick(); idle();
    n_vec++;
    if ({load_valid, load_error, load_data} !== {2'b11, 48'h0}) begin
      n_err++; $display("FAIL range_addr got %h want %h", {load_valid, load_error, load_data}, {2'b11, 48'h0});
    end
    // address 5 of row 0 would alias row 1 address 0 if the range check were missing
    set_store(0, 0, 5, 48'h1111_1111_1111, 48'h2222_2222_2222); tick(); idle();
    set_load(0, 1, 0, 1); tick(); idle();
    exp_v = {2'b10, 48'h7F00_8000_FFFF};
    n_vec++;
    if ({load_valid, load_error, load_data} !== exp_v) begin
      n_err++; $display("FAIL range_store_dropped got %h want %h", {load_valid, load_error, load_data}, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_store(1, k, 1, {3{16'(16'h0100 * (k + 1))}}, 48'h0100_0100_0100);
      else store = 1'b0;
      if (k >= 1) set_load(1, k - 1, 1, 1);
      tick();
      if (k >= 1) begin
        exp_v = {2'b10, {3{16'(16'h0100 * k)}}};
        n_vec++;
        if ({load_valid, load_error, load_data} !== exp_v) begin
          n_err++; $display("FAIL b2b_row%0d got %h want %h", k - 1, {load_valid, load_error, load_data}, exp_v);
        end
      end
    end
    idle();
  endtask

  task automatic test_clear;
    clear = 1'b1; clear_set = 0; tick(); idle();
    for (int m = 0; m < 4; m++) begin
      set_load(0, 1, 0, m); tick(); idle();
      n_vec++;
      if ({load_valid, load_error, load_data} !== {2'b10, 48'h0}) begin
        n_err++; $display("FAIL clear_set0_mode%0d got %h want %h", m, {load_valid, load_error, load_data}, {2'b10, 48'h0});
      end
    end
    set_load(1, 0, 2, 2); tick(); idle();
    exp_v = {2'b10, 48'h0180_0200_0400};
    n_vec++;
    if ({load_valid, load_error, load_data} !== exp_v) begin
      n_err++; $display("FAIL clear_set1_kept got %h want %h", {load_valid, load_error, load_data}, exp_v);
    end
    set_store(0, 0, 0, 48'h0100_0100_0100, 48'h0200_0200_0200);
    clear = 1'b1; clear_set = 0; tick(); idle();
    set_load(0, 0, 0, 0);
    clear = 1'b1; clear_set = 5; tick(); idle();
    exp_v = {2'b10, 48'h0200_0200_0200};
    n_vec++;
    if ({load_valid, load_error, load_data} !== exp_v) begin
      n_err++; $display("FAIL clear_store_same_cycle got %h want %h", {load_valid, load_error, load_data}, exp_v);
    end
    set_load(1, 0, 2, 1);
    clear = 1'b1; clear_set = 1; tick(); idle();
    n_vec++;
    if ({load_valid, load_error, load_data} !== {2'b10, 48'h0}) begin
      n_err++; $display("FAIL clear_same_cycle_load got %h want %h", {load_valid, load_error, load_data}, {2'b10, 48'h0});
    end
  endtask

  task automatic test_reset_pending;
    set_load(0, 0, 0, 0); reset = 1'b1; tick();
    n_vec++;
    if ({load_valid, load_error, load_data} !== 50'h0) begin
      n_err++; $display("FAIL reset_pending got %h want %h", {load_valid, load_error, load_data}, 50'h0);
    end
    reset = 1'b0; tick(); idle();
    set_load(0, 0, 0, 0); tick(); idle();
    n_vec++;
    if ({load_valid, load_error, load_data} !== {2'b10, 48'h0}) begin
      n_err++; $display("FAIL reset_invalidated got %h want %h", {load_valid, load_error, load_data}, {2'b10, 48'h0});
    end
    set_store(0, 0, 0, 48'h0100_0100_0100, 48'h0200_0200_0200); tick(); idle();
    set_load(0, 0, 0, 0); tick(); idle();
    exp_v = {2'b10, 48'h0200_0200_0200};
    n_vec++;
    if ({load_valid, load_error, load_data} !== exp_v) begin
      n_err++; $display("FAIL reset_restored got %h want %h", {load_valid, load_error, load_data}, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_product();
    test_saturation();
    test_bypass();
    test_range();
    test_back_to_back();
    test_clear();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
